// File: rtl/wind_vane_adc.sv
// wind_vane_adc: SPI master that reads one FRAME_BITS-clock wind-vane ADC frame per request
// and presents the extracted conversion with a one-cycle valid strobe.
module wind_vane_adc #(
    parameter int HALF_PERIOD = 4,
    parameter int FRAME_BITS  = 16,
    parameter int DATA_BITS   = 10,
    parameter int DATA_LSB    = 3
) (
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic                 start,
    output logic                 busy,
    output logic                 SPICLK,
    output logic                 nVaneCS,
    input  logic                 MISO,
    output logic [DATA_BITS-1:0] sample,
    output logic                 sample_valid,
    output logic                 null_err
);
    localparam int DW = HALF_PERIOD > 1 ? $clog2(HALF_PERIOD) : 1;
    localparam int BW = FRAME_BITS > 1 ? $clog2(FRAME_BITS) : 1;
    typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} state_t;
    state_t                r_state;
    logic [DW-1:0]         r_div;
    logic [BW-1:0]         r_bit;
    logic [FRAME_BITS-1:0] r_shift;
    logic                  w_last;
    assign w_last = r_div == DW'(HALF_PERIOD - 1);
    // Outputs are set on the transition edge into each state so the pins never decode combinationally.
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            r_state      <= IDLE;
            r_div        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            busy         <= 1'b0;
            SPICLK       <= 1'b1;
            nVaneCS      <= 1'b1;
            sample       <= '0;
            sample_valid <= 1'b0;
            null_err     <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            r_div        <= (r_state == IDLE || w_last) ? '0 : r_div + 1'b1;
            case (r_state)
                IDLE: if (start) begin
                    r_state <= SETUP;
                    r_bit   <= '0;
                    busy    <= 1'b1;
                    nVaneCS <= 1'b0;
                end
                SETUP: if (w_last) begin
                    r_state <= LOW;
                    SPICLK  <= 1'b0;
                end
                LOW: if (w_last) begin
                    r_state <= HIGH;
                    SPICLK  <= 1'b1;
                    r_shift <= {r_shift[FRAME_BITS-2:0], MISO};
                end
                HIGH: if (w_last) begin
                    if (r_bit == BW'(FRAME_BITS - 1)) begin
                        r_state <= HOLD;
                    end else begin
                        r_state <= LOW;
                        SPICLK  <= 1'b0;
                        r_bit   <= r_bit + 1'b1;
                    end
                end
                HOLD: if (w_last) begin
                    r_state      <= GAP;
                    nVaneCS      <= 1'b1;
                    sample       <= r_shift[DATA_LSB +: DATA_BITS];
                    null_err     <= r_shift[DATA_LSB + DATA_BITS];
                    sample_valid <= 1'b1;
                end
                GAP: if (w_last) begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
